// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin burst arbiter that shares the vga_adapter pixel-write
// port between four drawing engines and registers the owner's pixel onto colour/x/y/plot.
module vga_plot_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned X_MAX   = 159,
    parameter int unsigned Y_MAX   = 119
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [3:0]  last,
    input  logic [31:0] x_in,
    input  logic [27:0] y_in,
    input  logic [11:0] colour_in,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic [2:0]  colour_out,
    output logic [7:0]  xVal_out,
    output logic [6:0]  yVal_out,
    output logic        plot_out,
    output logic        busy,
    output logic        timeout
);
    // state | meaning
    // IDLE  | no owner; scan req from rr_ptr and grant the first requester found
    // BUSY  | one owner holds the port until it acks a last pixel or idles out
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [7:0] LP_TIMEOUT = TIMEOUT[7:0];
    localparam logic [7:0] LP_X_MAX   = X_MAX[7:0];
    localparam logic [6:0] LP_Y_MAX   = Y_MAX[6:0];

    state_t     r_state, w_state_nxt;
    logic [3:0] r_gnt, w_gnt_nxt;
    logic [1:0] r_owner, w_owner_nxt;
    logic [1:0] r_rr_ptr, w_rr_nxt;
    logic [7:0] r_idle_cnt, w_idle_cnt_nxt, w_idle_inc;
    logic       r_timeout, w_timeout_nxt;
    logic       w_found;
    logic [1:0] w_pick;
    logic [7:0] w_x;
    logic [6:0] w_y;
    logic [2:0] w_c;
    logic       w_ack_any;
    logic [2:0] r_colour;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic       r_plot;

    assign ack        = r_gnt & req;
    assign w_ack_any  = |ack;
    assign gnt        = r_gnt;
    assign busy       = (r_state == S_BUSY);
    assign timeout    = r_timeout;
    assign colour_out = r_colour;
    assign xVal_out   = r_x;
    assign yVal_out   = r_y;
    assign plot_out   = r_plot;

    // First requesting engine at or after rr_ptr, wrapping mod 4.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && req[r_rr_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_pick  = r_rr_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        w_x = x_in[7:0];
        w_y = y_in[6:0];
        w_c = colour_in[2:0];
        case (r_owner)
            2'd1: begin w_x = x_in[15:8];  w_y = y_in[13:7];  w_c = colour_in[5:3];  end
            2'd2: begin w_x = x_in[23:16]; w_y = y_in[20:14]; w_c = colour_in[8:6];  end
            2'd3: begin w_x = x_in[31:24]; w_y = y_in[27:21]; w_c = colour_in[11:9]; end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_owner_nxt    = r_owner;
        w_rr_nxt       = r_rr_ptr;
        w_idle_cnt_nxt = r_idle_cnt;
        w_timeout_nxt  = 1'b0;
        w_idle_inc     = r_idle_cnt + 8'd1;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt      = 4'b0001 << w_pick;
                    w_owner_nxt    = w_pick;
                    w_idle_cnt_nxt = '0;
                    w_state_nxt    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (req[r_owner]) begin
                    w_idle_cnt_nxt = '0;
                    if (last[r_owner]) begin
                        w_gnt_nxt   = '0;
                        w_rr_nxt    = r_owner + 2'd1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_idle_inc == LP_TIMEOUT) begin
                    // Owner went quiet too long: reclaim the port so others are not starved.
                    w_gnt_nxt      = '0;
                    w_rr_nxt       = r_owner + 2'd1;
                    w_idle_cnt_nxt = '0;
                    w_timeout_nxt  = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_idle_cnt_nxt = w_idle_inc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Out-of-range pixels are consumed and their coordinates kept, but never written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_colour <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_plot   <= 1'b0;
        end else if (w_ack_any) begin
            r_colour <= w_c;
            r_x      <= w_x;
            r_y      <= w_y;
            r_plot   <= (w_x <= LP_X_MAX) && (w_y <= LP_Y_MAX);
        end else begin
            r_plot   <= 1'b0;
        end
    end
endmodule
